// File: rtl/jtag_tdo_mux.sv
// jtag_tdo_mux: TDO output stage for the JTAG TAP.
// Selects the IR or one of NUM_DR data-register channels onto TDO.
// Selected channels get a captured {ahb_busy, ahb_error} status prefix,
// sent ahead of the DR data. The external DR shift is held off while the
// prefix is going out.
// TDO/TDO_oe are registered on the falling edge of TCK. The block also keeps
// a saturating per-session shift counter and a sticky illegal-select flag.
//
// Ports:
//   TCK, TRST         TAP clock, asynchronous active-low reset
//   tlr_reset         synchronous clear (Test-Logic-Reset)
//   capture_dr        TAP in Capture-DR (loads status prefix, zeroes counter)
//   dr_shift/ir_shift TAP in Shift-DR / Shift-IR
//   instr_out         IR serial output bit
//   dr_sel            decoded DR channel select
//   dr_out            per-channel DR serial output bits
//   ahb_busy/error    AHB status sampled at Capture-DR
//   TDO, TDO_oe       registered serial output and output enable
//   dr_shift_gate     combinational shift enable for the external DRs
//   shift_cnt         bits shifted in the current DR session (saturating)
//   sel_err           sticky illegal-select / illegal-state flag
module jtag_tdo_mux #(
    parameter int unsigned       NUM_DR      = 4,
    parameter int unsigned       SEL_W       = (NUM_DR > 1) ? $clog2(NUM_DR) : 1,
    // The status field is fixed to {ahb_busy, ahb_error}, so this must stay 2.
    parameter int unsigned       STATUS_W    = 2,
    parameter logic [NUM_DR-1:0] PREFIX_MASK = NUM_DR'(4'b0100),
    parameter int unsigned       CNT_W       = 8
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              tlr_reset,
    input  logic              capture_dr,
    input  logic              dr_shift,
    input  logic              ir_shift,
    input  logic              instr_out,
    input  logic [SEL_W-1:0]  dr_sel,
    input  logic [NUM_DR-1:0] dr_out,
    input  logic              ahb_busy,
    input  logic              ahb_error,
    output logic              TDO,
    output logic              TDO_oe,
    output logic              dr_shift_gate,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              sel_err
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;
    localparam int unsigned PRE_W    = $clog2(STATUS_W + 1);

    logic [STATUS_W-1:0] status_sr;
    logic [PRE_W-1:0]    pre_left;
    logic [SEL_SPAN-1:0] dr_out_pad;
    logic [SEL_SPAN-1:0] mask_pad;
    logic                sel_ok;
    logic                prefix_active;
    logic                dr_only_shift;
    logic                next_bit;

    // Pad to the full select range so out-of-range selects index real (zero) bits.
    assign dr_out_pad = SEL_SPAN'(dr_out);
    assign mask_pad   = SEL_SPAN'(PREFIX_MASK);

    assign sel_ok        = ({1'b0, dr_sel} < (SEL_W + 1)'(NUM_DR));
    assign prefix_active = (pre_left != '0);
    assign dr_only_shift = dr_shift & ~ir_shift;

    // External DRs hold during the prefix so no data bit is lost.
    assign dr_shift_gate = dr_only_shift & ~prefix_active;

    // TDO source; IR wins when both shift states are (illegally) high.
    always_comb begin
        next_bit = 1'b0;
        if (ir_shift) begin
            next_bit = instr_out;
        end else if (dr_shift && prefix_active) begin
            next_bit = status_sr[0];
        end else if (dr_shift && sel_ok) begin
            next_bit = dr_out_pad[dr_sel];
        end
    end

    // Rising-edge state: status prefix, session counter, sticky error.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            status_sr <= '0;
            pre_left  <= '0;
            shift_cnt <= '0;
            sel_err   <= 1'b0;
        end else if (tlr_reset) begin
            status_sr <= '0;
            pre_left  <= '0;
            shift_cnt <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (capture_dr) begin
                // ahb_error in the LSB so it goes out first.
                status_sr <= STATUS_W'({ahb_busy, ahb_error});
                pre_left  <= mask_pad[dr_sel] ? PRE_W'(STATUS_W) : '0;
                shift_cnt <= '0;
            end else if (dr_only_shift) begin
                if (shift_cnt != {CNT_W{1'b1}}) begin
                    shift_cnt <= shift_cnt + CNT_W'(1);
                end
                if (prefix_active) begin
                    status_sr <= status_sr >> 1;
                    pre_left  <= pre_left - PRE_W'(1);
                end
            end
            if (dr_shift && (!sel_ok || ir_shift)) begin
                sel_err <= 1'b1;
            end
        end
    end

    // Falling-edge output register: bit stays valid across the next rising edge.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_oe <= 1'b0;
        end else if (tlr_reset) begin
            TDO    <= 1'b0;
            TDO_oe <= 1'b0;
        end else begin
            TDO    <= next_bit;
            TDO_oe <= ir_shift | dr_shift;
        end
    end

endmodule

// File: tb/tb_jtag_tdo_mux.sv
// Self-checking bench for jtag_tdo_mux (NUM_DR=3, channel 2 prefixed).
module tb_jtag_tdo_mux;

    localparam int NUM_DR = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              TCK        = 1'b0;
    logic              TRST       = 1'b1;
    logic              tlr_reset  = 1'b0;
    logic              capture_dr = 1'b0;
    logic              dr_shift   = 1'b0;
    logic              ir_shift   = 1'b0;
    logic              instr_out  = 1'b0;
    logic [SEL_W-1:0]  dr_sel     = '0;
    logic [NUM_DR-1:0] dr_out     = '0;
    logic              ahb_busy   = 1'b0;
    logic              ahb_error  = 1'b0;
    logic              TDO;
    logic              TDO_oe;
    logic              dr_shift_gate;
    logic [CNT_W-1:0]  shift_cnt;
    logic              sel_err;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    jtag_tdo_mux #(
        .NUM_DR     (NUM_DR),
        .SEL_W      (SEL_W),
        .STATUS_W   (2),
        .PREFIX_MASK(3'b100),
        .CNT_W      (CNT_W)
    ) dut (
        .TCK          (TCK),
        .TRST         (TRST),
        .tlr_reset    (tlr_reset),
        .capture_dr   (capture_dr),
        .dr_shift     (dr_shift),
        .ir_shift     (ir_shift),
        .instr_out    (instr_out),
        .dr_sel       (dr_sel),
        .dr_out       (dr_out),
        .ahb_busy     (ahb_busy),
        .ahb_error    (ahb_error),
        .TDO          (TDO),
        .TDO_oe       (TDO_oe),
        .dr_shift_gate(dr_shift_gate),
        .shift_cnt    (shift_cnt),
        .sel_err      (sel_err)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending prefix bits as a queue, plain session count, sticky flag.
    bit pq[$];
    int m_cnt = 0;
    bit m_err = 1'b0;

    function automatic bit is_prefixed(input int ch);
        return ch == 2;
    endfunction

    function automatic bit model_bit();
        logic [3:0] dv;
        dv = {1'b0, dr_out};
        if (ir_shift) return instr_out;
        if (dr_shift) begin
            if (pq.size() > 0) return pq[0];
            if (int'(dr_sel) < NUM_DR) return dv[dr_sel];
        end
        return 1'b0;
    endfunction

    always @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            pq.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else if (tlr_reset) begin
            pq.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (capture_dr) begin
                pq.delete();
                if (int'(dr_sel) < NUM_DR && is_prefixed(int'(dr_sel))) begin
                    pq.push_back(ahb_error);
                    pq.push_back(ahb_busy);
                end
                m_cnt = 0;
            end else if (dr_shift && !ir_shift) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (pq.size() > 0) void'(pq.pop_front());
            end
            if (dr_shift && (int'(dr_sel) >= NUM_DR || ir_shift)) m_err = 1'b1;
        end
    end

    // Every-cycle compare, just after the falling edge.
    always @(negedge TCK) begin
        bit e_tdo, e_oe, e_gate, e_err;
        int e_cnt;
        if (!TRST || tlr_reset) begin
            e_tdo = 1'b0;
            e_oe  = 1'b0;
        end else begin
            e_tdo = model_bit();
            e_oe  = ir_shift | dr_shift;
        end
        e_gate = dr_shift && !ir_shift && (pq.size() == 0);
        e_cnt  = m_cnt;
        e_err  = m_err;
        #1;
        if (cmp_en) begin
            chk("cyc_tdo", int'(TDO), int'(e_tdo));
            chk("cyc_oe", int'(TDO_oe), int'(e_oe));
            chk("cyc_gate", int'(dr_shift_gate), int'(e_gate));
            chk("cyc_cnt", int'(shift_cnt), e_cnt);
            chk("cyc_err", int'(sel_err), int'(e_err));
        end
    end

    // One TAP cycle: sample TDO after the falling edge, return just after the rising edge.
    task automatic run_cycle(output bit t, output bit g, output bit oe);
        @(negedge TCK);
        #2;
        t  = TDO;
        g  = dr_shift_gate;
        oe = TDO_oe;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit t, g, oe;
        bit ir_pat [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit ch1_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit ch2_dat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit ch2_tdo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bit ch2_gate [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        #1 TRST = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge TCK);
        #1;
        chk("reset_tdo", int'(TDO), 0);
        chk("reset_cnt", int'(shift_cnt), 0);
        chk("reset_err", int'(sel_err), 0);
        TRST = 1'b1;

        // IR shift
        ir_shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_out = ir_pat[i];
            run_cycle(t, g, oe);
            chk("ir_tdo", int'(t), int'(ir_pat[i]));
            chk("ir_oe", int'(oe), 1);
            chk("ir_gate", int'(g), 0);
        end
        ir_shift = 1'b0;

        // Unprefixed channel 1
        dr_sel = 2'd1;
        capture_dr = 1'b1;
        run_cycle(t, g, oe);
        capture_dr = 1'b0;
        dr_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dr_out = 3'($urandom);
            dr_out[1] = ch1_pat[i];
            run_cycle(t, g, oe);
            chk("ch1_tdo", int'(t), int'(ch1_pat[i]));
            chk("ch1_gate", int'(g), 1);
        end
        dr_shift = 1'b0;
        chk("ch1_cnt", int'(shift_cnt), 8);

        // Prefixed channel 2
        dr_sel = 2'd2;
        ahb_busy = 1'b1;
        ahb_error = 1'b0;
        capture_dr = 1'b1;
        run_cycle(t, g, oe);
        capture_dr = 1'b0;
        dr_shift = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ahb_busy  = 1'($urandom);
            ahb_error = 1'($urandom);
            dr_out = 3'($urandom);
            if (i >= 2) dr_out[2] = ch2_dat[i-2];
            run_cycle(t, g, oe);
            chk("ch2_tdo", int'(t), int'(ch2_tdo[i]));
            chk("ch2_gate", int'(g), int'(ch2_gate[i]));
        end
        dr_shift = 1'b0;
        chk("ch2_cnt", int'(shift_cnt), 6);

        // Counter saturation
        dr_sel = 2'd0;
        capture_dr = 1'b1;
        run_cycle(t, g, oe);
        capture_dr = 1'b0;
        dr_shift = 1'b1;
        for (int i = 0; i < 300; i++) begin
            dr_out = 3'($urandom);
            run_cycle(t, g, oe);
        end
        dr_shift = 1'b0;
        chk("sat_cnt", int'(shift_cnt), 255);

        // Illegal select
        dr_sel = 2'd3;
        dr_out = 3'b111;
        dr_shift = 1'b1;
        run_cycle(t, g, oe);
        chk("badsel_tdo", int'(t), 0);
        chk("badsel_err", int'(sel_err), 1);

        // Test-Logic-Reset for one cycle while shifting
        dr_sel = 2'd0;
        tlr_reset = 1'b1;
        run_cycle(t, g, oe);
        chk("tlr_tdo", int'(t), 0);
        chk("tlr_oe", int'(oe), 0);
        chk("tlr_err", int'(sel_err), 0);
        tlr_reset = 1'b0;

        // Both shift states high
        ir_shift = 1'b1;
        instr_out = 1'b1;
        dr_out = 3'b000;
        run_cycle(t, g, oe);
        chk("both_tdo1", int'(t), 1);
        chk("both_err", int'(sel_err), 1);
        instr_out = 1'b0;
        dr_out = 3'b111;
        run_cycle(t, g, oe);
        chk("both_tdo0", int'(t), 0);
        ir_shift = 1'b0;
        dr_shift = 1'b0;

        // Async reset mid-shift
        dr_sel = 2'd1;
        capture_dr = 1'b1;
        run_cycle(t, g, oe);
        capture_dr = 1'b0;
        dr_shift = 1'b1;
        dr_out = 3'b010;
        repeat (5) run_cycle(t, g, oe);
        chk("pre_rst_cnt", int'(shift_cnt), 5);
        chk("pre_rst_tdo", int'(TDO), 1);
        #2 TRST = 1'b0;
        #1;
        chk("arst_tdo", int'(TDO), 0);
        chk("arst_oe", int'(TDO_oe), 0);
        chk("arst_cnt", int'(shift_cnt), 0);
        chk("arst_err", int'(sel_err), 0);
        dr_shift = 1'b0;
        @(posedge TCK);
        #1 TRST = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            capture_dr = (r < 8);
            tlr_reset  = (r >= 98);
            dr_shift   = ($urandom_range(0, 9) < 8);
            ir_shift   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) == 0) dr_sel = 2'd3;
                else dr_sel = 2'($urandom_range(0, 2));
            end
            dr_out    = 3'($urandom);
            instr_out = 1'($urandom);
            ahb_busy  = 1'($urandom);
            ahb_error = 1'($urandom);
            run_cycle(t, g, oe);
        end
        capture_dr = 1'b0;
        tlr_reset  = 1'b0;
        dr_shift   = 1'b0;
        ir_shift   = 1'b0;
        run_cycle(t, g, oe);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_tdo_mux.md
Name: jtag_tdo_mux

Overview:
- Parametrised TDO output stage for the JTAG TAP. Selects between the instruction register and NUM_DR data-register channels.
- Optionally prefixes a captured AHB status field ahead of the data on selected channels, and holds off the external DR shift while the prefix is being shifted out.
- Registers TDO and TDO_oe on the falling edge of TCK, keeps a per-session shift-bit counter, and reports illegal selections through a sticky flag.

Parameters:
- NUM_DR, 4, number of data-register channels (≥1).
- SEL_W, $clog2(NUM_DR) (minimum 1), width of dr_sel.
- STATUS_W, 2, number of status prefix bits (fixed field {ahb_busy, ahb_error}; must be 2).
- PREFIX_MASK, 4'b0100, bit i=1 means channel i gets the status prefix.
- CNT_W, 8, width of the shift counter.

Ports:
- TCK, input, 1, TAP clock.
- TRST, input, 1, asynchronous active-low reset.
- tlr_reset, input, 1, synchronous clear (Test-Logic-Reset).
- capture_dr, input, 1, TAP is in Capture-DR.
- dr_shift, input, 1, TAP is in Shift-DR.
- ir_shift, input, 1, TAP is in Shift-IR.
- instr_out, input, 1, IR serial output bit.
- dr_sel, input, SEL_W, decoded DR channel select.
- dr_out, input, NUM_DR, per-channel DR serial output bits.
- ahb_busy, input, 1, AHB transaction in progress.
- ahb_error, input, 1, AHB error flag.
- TDO, output, 1, registered serial output.
- TDO_oe, output, 1, registered output enable.
- dr_shift_gate, output, 1, shift enable for the external DRs.
- shift_cnt, output, CNT_W, bits shifted in the current DR session.
- sel_err, output, 1, sticky illegal-select / illegal-state flag.

Behaviour:
- Async reset (TRST=0): TDO=0, TDO_oe=0, shift_cnt=0, sel_err=0, status_sr=0, pre_left=0. Takes effect immediately, including mid-shift.
- Rising-edge TCK, evaluated in priority order:
  - tlr_reset=1: clear status_sr, pre_left, shift_cnt and sel_err; nothing else updates.
  - capture_dr=1: status_sr <= {ahb_busy, ahb_error}, so ahb_error is the LSB and is sent first. pre_left <= PREFIX_MASK[dr_sel] ? STATUS_W : 0. shift_cnt <= 0.
  - dr_shift=1 and ir_shift=0:
    - shift_cnt increments, saturating at 2^CNT_W-1.
    - If pre_left≠0: status_sr shifts right by 1 and pre_left decrements.
  - sel_err is set (sticky) when:
    - dr_shift=1 and dr_sel ≥ NUM_DR, or
    - dr_shift=1 and ir_shift=1.
- Combinational TDO source (next_bit):
  - ir_shift=1: instr_out (IR has priority when both shifts are high).
  - else dr_shift=1 and pre_left≠0: status_sr[0].
  - else dr_shift=1 and dr_sel<NUM_DR: dr_out[dr_sel].
  - otherwise: 0.
- dr_shift_gate = dr_shift & ~ir_shift & (pre_left==0), purely combinational. During the prefix the external DR holds its value, so the first data bit follows the last prefix bit without loss.
- Falling-edge TCK:
  - tlr_reset=1: TDO <= 0, TDO_oe <= 0.
  - otherwise: TDO <= next_bit, TDO_oe <= ir_shift | dr_shift.
- Latency: each bit appears on TDO at the falling edge of the cycle in which it is current, and stays valid through the following rising edge.
- Channels without a prefix: data starts at the first Shift-DR falling edge. shift_cnt counts prefix bits as well as data bits.
- Capture-DR again mid-session reloads the prefix and zeroes the counter.
- Channel change during a session: dr_sel is used as-is each cycle; the prefix decision is fixed at Capture-DR.

Test Plan:
- Reset mid-shift: dr_shift=1 with shift_cnt=5, drive TRST=0 → TDO=0, TDO_oe=0, shift_cnt=0, sel_err=0 immediately, without waiting for a TCK edge.
- IR shift: ir_shift=1, instr_out=1,0,1,1 over 4 cycles → TDO after each falling edge is 1,0,1,1; TDO_oe=1; dr_shift_gate=0.
- Unprefixed channel 1: capture_dr, then 8 dr_shift cycles with dr_out[1]=1,1,0,1,0,0,1,0 → TDO matches that sequence; dr_shift_gate=1 throughout; shift_cnt=8.
- Prefixed channel 2: capture with ahb_busy=1, ahb_error=0, then 6 shift cycles with dr_out[2]=1,0,1,1 → TDO=0,1,1,0,1,1; dr_shift_gate=0,0,1,1,1,1; shift_cnt=6.
- Saturation: CNT_W=8, 300 consecutive shift cycles → shift_cnt holds at 255.
- Illegal cases:
  - NUM_DR=3, dr_sel=3 during dr_shift → TDO=0 and sel_err=1 after the rising edge.
  - ir_shift=dr_shift=1 → TDO=instr_out and sel_err=1.
  - tlr_reset=1 for one cycle → sel_err=0, TDO=0, TDO_oe=0.
